// File: rtl/stack_cpu_controller_if.sv
// Control bus between the stack CPU controller and its datapath.
// The controller takes the master modport; the datapath takes the slave modport.
interface stack_cpu_controller_if #(
  parameter int unsigned OP_W = 3
);
  logic [OP_W-1:0] op;
  logic            Zero;
  logic            MemWrite;
  logic            AdrSrc;
  logic            PCWrite;
  logic            IRWrite;
  logic            AWriteEnable;
  logic            BWriteEnable;
  logic [1:0]      ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ResultSrc;
  logic [1:0]      ALUControl;
  logic            push;
  logic            pop;
  logic            tos;
  logic            A_or_B_stack_out_sel;
  logic            instr_retire;

  modport master (
    input  op, Zero,
    output MemWrite, AdrSrc, PCWrite, IRWrite, AWriteEnable, BWriteEnable,
           ALUSrcA, ALUSrcB, ResultSrc, ALUControl, push, pop, tos,
           A_or_B_stack_out_sel, instr_retire
  );

  modport slave (
    output op, Zero,
    input  MemWrite, AdrSrc, PCWrite, IRWrite, AWriteEnable, BWriteEnable,
           ALUSrcA, ALUSrcB, ResultSrc, ALUControl, push, pop, tos,
           A_or_B_stack_out_sel, instr_retire
  );
endinterface

// File: rtl/stack_cpu_controller.sv
// Multicycle control FSM for the 8-bit stack CPU.
// Fetches, decodes and executes one instruction per pass; pulses instr_retire
// in the last state of each instruction.
// Optional: define CTRL_PERF_CNT_EN to add the retired_cnt counter output.
module stack_cpu_controller #(
  parameter int unsigned OP_W = 3
`ifdef CTRL_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  stack_cpu_controller_if.master bus
`ifdef CTRL_PERF_CNT_EN
  , output logic [CNT_W-1:0]     retired_cnt
`endif
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_PUSHWB = 4'd4;
  localparam logic [3:0] S_POPB   = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_POPA   = 4'd7;
  localparam logic [3:0] S_EXEC   = 4'd8;
  localparam logic [3:0] S_ALUWB  = 4'd9;
  localparam logic [3:0] S_JMP    = 4'd10;
  localparam logic [3:0] S_PEEK   = 4'd11;
  localparam logic [3:0] S_JZT    = 4'd12;

  localparam logic [OP_W-1:0] OP_PUSH = OP_W'(0);
  localparam logic [OP_W-1:0] OP_POP  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JZ   = OP_W'(7);

  logic [3:0]      state;
  logic [3:0]      next_state;
  logic [OP_W-1:0] opc;

  assign opc = bus.op;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state and Moore output decode; only PCWrite in JZT looks at Zero.
  always_comb begin
    next_state               = S_FETCH;
    bus.MemWrite             = 1'b0;
    bus.AdrSrc               = 1'b0;
    bus.PCWrite              = 1'b0;
    bus.IRWrite              = 1'b0;
    bus.AWriteEnable         = 1'b0;
    bus.BWriteEnable         = 1'b0;
    bus.ALUSrcA              = 2'b00;
    bus.ALUSrcB              = 2'b00;
    bus.ResultSrc            = 2'b00;
    bus.ALUControl           = 2'b00;
    bus.push                 = 1'b0;
    bus.pop                  = 1'b0;
    bus.tos                  = 1'b0;
    bus.A_or_B_stack_out_sel = 1'b0;
    bus.instr_retire         = 1'b0;

    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = 1'b1;
        next_state    = S_DECODE;
      end
      S_DECODE: begin
        case (opc)
          OP_PUSH:                        next_state = S_MEMRD;
          OP_POP, OP_ADD, OP_SUB, OP_AND: next_state = S_POPB;
          OP_NOT:                         next_state = S_POPA;
          OP_JMP:                         next_state = S_JMP;
          OP_JZ:                          next_state = S_PEEK;
          default:                        next_state = S_FETCH;
        endcase
      end
      S_MEMRD: begin
        bus.AdrSrc    = 1'b1;
        bus.ResultSrc = 2'b11;
        next_state    = S_PUSHWB;
      end
      S_PUSHWB: begin
        bus.ResultSrc    = 2'b01;
        bus.push         = 1'b1;
        bus.instr_retire = 1'b1;
      end
      S_POPB: begin
        bus.pop                  = 1'b1;
        bus.A_or_B_stack_out_sel = 1'b1;
        bus.BWriteEnable         = 1'b1;
        next_state               = (opc == OP_POP) ? S_MEMWR : S_POPA;
      end
      S_MEMWR: begin
        bus.AdrSrc       = 1'b1;
        bus.ResultSrc    = 2'b11;
        bus.MemWrite     = 1'b1;
        bus.instr_retire = 1'b1;
      end
      S_POPA: begin
        bus.pop          = 1'b1;
        bus.AWriteEnable = 1'b1;
        next_state       = S_EXEC;
      end
      S_EXEC: begin
        bus.ALUSrcA = 2'b10;
        case (opc)
          OP_SUB: bus.ALUControl = 2'b01;
          OP_AND: bus.ALUControl = 2'b10;
          OP_NOT: begin
            bus.ALUControl = 2'b11;
            bus.ALUSrcB    = 2'b11;
          end
          default: bus.ALUControl = 2'b00;
        endcase
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        bus.push         = 1'b1;
        bus.instr_retire = 1'b1;
      end
      S_JMP: begin
        bus.ResultSrc    = 2'b11;
        bus.PCWrite      = 1'b1;
        bus.instr_retire = 1'b1;
      end
      S_PEEK: begin
        bus.tos          = 1'b1;
        bus.AWriteEnable = 1'b1;
        next_state       = S_JZT;
      end
      S_JZT: begin
        bus.ALUSrcA      = 2'b10;
        bus.ALUSrcB      = 2'b11;
        bus.ResultSrc    = 2'b11;
        bus.PCWrite      = bus.Zero;
        bus.instr_retire = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q;

  // Retired-instruction counter, wraps naturally at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                retired_q <= '0;
    else if (bus.instr_retire) retired_q <= retired_q + CNT_W'(1);
  end

  assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Self-checking bench for stack_cpu_controller: expected per-cycle control
// vectors are queued when an opcode is issued and popped as the DUT steps.
module tb_stack_cpu_controller;

  typedef enum int {
    P_FETCH, P_DECODE, P_MEMRD, P_PUSHWB, P_POPB, P_MEMWR,
    P_POPA, P_EXEC, P_ALUWB, P_JMP, P_PEEK, P_JZT
  } phase_e;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   retires_seen = 0;
  logic [18:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  stack_cpu_controller_if bus ();

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] retired_cnt;
  stack_cpu_controller dut (.clk(clk), .reset(reset), .bus(bus), .retired_cnt(retired_cnt));
`else
  stack_cpu_controller dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed view of every controller output.
  function automatic logic [18:0] obs_vec();
    return {bus.MemWrite, bus.AdrSrc, bus.PCWrite, bus.IRWrite,
            bus.AWriteEnable, bus.BWriteEnable, bus.ALUSrcA, bus.ALUSrcB,
            bus.ResultSrc, bus.ALUControl, bus.push, bus.pop, bus.tos,
            bus.A_or_B_stack_out_sel, bus.instr_retire};
  endfunction

  // Reference control vector for one phase, straight from the state table.
  function automatic logic [18:0] exp_vec(input phase_e p, input logic [2:0] o, input logic z);
    logic mw = 0, as = 0, pw = 0, iw = 0, aw = 0, bw = 0;
    logic [1:0] sa = 0, sb = 0, rs = 0, ac = 0;
    logic pu = 0, po = 0, tt = 0, sel = 0, ret = 0;
    case (p)
      P_FETCH:  begin iw = 1; sb = 2'b10; rs = 2'b10; pw = 1; end
      P_DECODE: ;
      P_MEMRD:  begin as = 1; rs = 2'b11; end
      P_PUSHWB: begin rs = 2'b01; pu = 1; ret = 1; end
      P_POPB:   begin po = 1; sel = 1; bw = 1; end
      P_MEMWR:  begin as = 1; rs = 2'b11; mw = 1; ret = 1; end
      P_POPA:   begin po = 1; aw = 1; end
      P_EXEC: begin
        sa = 2'b10;
        sb = (o == 3'b101) ? 2'b11 : 2'b00;
        ac = (o == 3'b011) ? 2'b01 : (o == 3'b100) ? 2'b10 : (o == 3'b101) ? 2'b11 : 2'b00;
      end
      P_ALUWB:  begin rs = 2'b00; pu = 1; ret = 1; end
      P_JMP:    begin rs = 2'b11; pw = 1; ret = 1; end
      P_PEEK:   begin tt = 1; aw = 1; end
      P_JZT:    begin sa = 2'b10; sb = 2'b11; rs = 2'b11; pw = z; ret = 1; end
      default: ;
    endcase
    return {mw, as, pw, iw, aw, bw, sa, sb, rs, ac, pu, po, tt, sel, ret};
  endfunction

  task automatic q_phase(input phase_e p, input logic [2:0] o, input logic z);
    exp_q.push_back(exp_vec(p, o, z));
    tag_q.push_back($sformatf("op%0d_z%0d_%s", o, z, p.name()));
  endtask

  // Queue the full expected phase sequence for one instruction.
  task automatic issue(input logic [2:0] o, input logic z);
    q_phase(P_FETCH, o, z);
    q_phase(P_DECODE, o, z);
    case (o)
      3'b000: begin q_phase(P_MEMRD, o, z); q_phase(P_PUSHWB, o, z); end
      3'b001: begin q_phase(P_POPB, o, z);  q_phase(P_MEMWR, o, z);  end
      3'b101: begin q_phase(P_POPA, o, z);  q_phase(P_EXEC, o, z); q_phase(P_ALUWB, o, z); end
      3'b110: q_phase(P_JMP, o, z);
      3'b111: begin q_phase(P_PEEK, o, z);  q_phase(P_JZT, o, z);    end
      default: begin
        q_phase(P_POPB, o, z); q_phase(P_POPA, o, z);
        q_phase(P_EXEC, o, z); q_phase(P_ALUWB, o, z);
      end
    endcase
  endtask

  // Compare n queued entries, one per cycle, starting at the current negedge.
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      logic [18:0] o;
      o = obs_vec();
      if (o[0]) retires_seen++;
      chk(tag_q.pop_front(), 32'(o), 32'(exp_q.pop_front()));
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input logic [2:0] o, input logic z);
    bus.op   = o;
    bus.Zero = z;
    issue(o, z);
    drain(exp_q.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    bus.op   = 3'b000;
    bus.Zero = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("in_reset", 32'(obs_vec()), 32'd0);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("idle", 32'(obs_vec()), 32'd0);
    @(negedge clk);

    for (int k = 0; k < 7; k++) run_instr(3'(k), 1'b0);
    run_instr(3'b111, 1'b1);
    run_instr(3'b111, 1'b0);
    chk("retire_pulses", 32'(retires_seen), 32'd9);

    // Reset asserted in the middle of an ADD's EXEC cycle.
    bus.op = 3'b010;
    issue(3'b010, 1'b0);
    drain(4);
    chk(tag_q.pop_front(), 32'(obs_vec()), 32'(exp_q.pop_front()));
    exp_q.delete();
    tag_q.delete();
    #1 reset = 1'b0;
    #1 chk("async_reset", 32'(obs_vec()), 32'd0);
`ifdef CTRL_PERF_CNT_EN
    chk("cnt_reset", 32'(retired_cnt), 32'd0);
`endif
    repeat (2) begin
      @(negedge clk);
      chk("held_reset", 32'(obs_vec()), 32'd0);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("idle_after_abort", 32'(obs_vec()), 32'd0);
    @(negedge clk);

    run_instr(3'b000, 1'b0);
    run_instr(3'b000, 1'b0);
    run_instr(3'b010, 1'b0);
    run_instr(3'b001, 1'b0);
    run_instr(3'b110, 1'b0);
`ifdef CTRL_PERF_CNT_EN
    chk("cnt_five", 32'(retired_cnt), 32'd5);
    force dut.retired_q = 16'hffff;
    #1 release dut.retired_q;
    chk("cnt_preload", 32'(retired_cnt), 32'hffff);
    run_instr(3'b110, 1'b0);
    chk("cnt_wrap", 32'(retired_cnt), 32'd0);
`endif
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
